// File: rtl/multiplier_fu_if.sv
// Issue/CDB bundle between the multiply reservation table, the multiply unit
// and the CDB arbiter. The issuing side is the master; the unit is the slave.
interface multiplier_fu_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 3,
    parameter int PREG_WIDTH   = 6
);
    logic                    start_calculate;
    logic [2:0]              funct3;
    logic [ROB_ID_WIDTH-1:0] rob_id_in;
    logic [PREG_WIDTH-1:0]   rd_s_in;
    logic [DATA_WIDTH-1:0]   rs1_v;
    logic [DATA_WIDTH-1:0]   rs2_v;
    logic                    fu_ready;
    logic                    ready_for_writeback;
    logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
    logic [PREG_WIDTH-1:0]   cdb_rd_s;
    logic [DATA_WIDTH-1:0]   cdb_rd_v;
    logic                    cdb_ack;

    modport master (
        output start_calculate, funct3, rob_id_in, rd_s_in, rs1_v, rs2_v, cdb_ack,
        input  fu_ready, ready_for_writeback, cdb_rob_id, cdb_rd_s, cdb_rd_v
    );

    modport slave (
        input  start_calculate, funct3, rob_id_in, rd_s_in, rs1_v, rs2_v, cdb_ack,
        output fu_ready, ready_for_writeback, cdb_rob_id, cdb_rd_s, cdb_rd_v
    );
endinterface

// File: rtl/multiplier_fu.sv
// RV32M multiply functional unit: radix-2 shift-add over 32 cycles on operand
// magnitudes, sign fix-up at the end, result held on the CDB lane until acked.
module multiplier_fu #(
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 3,
    parameter int PREG_WIDTH   = 6
) (
    input logic            clk,
    input logic            rst,
    multiplier_fu_if.slave mul
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [1:0]                op;
    logic                      neg;
    logic [DATA_WIDTH-1:0]     mcand;
    logic [DATA_WIDTH-1:0]     mplier;
    logic [2*DATA_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]          count;

    logic [ROB_ID_WIDTH-1:0]   rob_id_q;
    logic [PREG_WIDTH-1:0]     rd_s_q;
    logic [DATA_WIDTH-1:0]     rd_v_q;

    logic                      ready;
    logic                      issue;
    logic                      last_iter;
    logic                      sign1;
    logic                      sign2;
    logic [DATA_WIDTH:0]       hi_sum;
    logic [2*DATA_WIDTH-1:0]   acc_step;
    logic [DATA_WIDTH-1:0]     mplier_step;

    // Unsigned magnitude of a possibly signed operand. The most negative value
    // maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_WIDTH-1:0] magnitude(
        input logic [DATA_WIDTH-1:0] x,
        input logic                  is_neg
    );
        logic signed [DATA_WIDTH-1:0] sx;
        sx = $signed(x);
        if (is_neg) begin
            sx = -sx;
        end
        return $unsigned(sx);
    endfunction

    // Apply the product sign and pick the low or high word by operation.
    function automatic logic [DATA_WIDTH-1:0] select_result(
        input logic [2*DATA_WIDTH-1:0] prod_mag,
        input logic                    prod_neg,
        input logic [1:0]              sel_op
    );
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = $signed(prod_mag);
        if (prod_neg) begin
            prod = -prod;
        end
        if (sel_op == 2'b00) begin
            return prod[DATA_WIDTH-1:0];
        end
        return prod[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    assign ready     = (state == IDLE) && !rst;
    assign issue     = mul.start_calculate && ready;
    assign last_iter = (state == CALC) && (count == CNT_W'(DATA_WIDTH - 1));

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH.
    assign sign1 = mul.rs1_v[DATA_WIDTH-1] && (mul.funct3[1:0] == 2'b01 || mul.funct3[1:0] == 2'b10);
    assign sign2 = mul.rs2_v[DATA_WIDTH-1] && (mul.funct3[1:0] == 2'b01);

    // One shift-add iteration: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        hi_sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_step    = {hi_sum, acc[DATA_WIDTH-1:1]};
        mplier_step = mplier >> 1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: issue starts a calculation, the 32nd iteration finishes
    // it, and only an ack in DONE releases the lane.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue)       state_next = CALC;
            CALC:    if (last_iter)   state_next = DONE;
            DONE:    if (mul.cdb_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at issue, iteration in CALC, result load on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= '0;
            neg      <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            rob_id_q <= '0;
            rd_s_q   <= '0;
            rd_v_q   <= '0;
        end else if (issue) begin
            op       <= mul.funct3[1:0];
            neg      <= sign1 ^ sign2;
            mcand    <= magnitude(mul.rs1_v, sign1);
            mplier   <= magnitude(mul.rs2_v, sign2);
            acc      <= '0;
            count    <= '0;
            rob_id_q <= mul.rob_id_in;
            rd_s_q   <= mul.rd_s_in;
        end else if (state == CALC) begin
            acc    <= acc_step;
            mplier <= mplier_step;
            if (!last_iter) begin
                count <= count + 1'b1;
            end
            if (last_iter) begin
                rd_v_q <= select_result(acc_step, neg, op);
            end
        end
    end

    assign mul.fu_ready            = ready;
    assign mul.ready_for_writeback = (state == DONE);
    assign mul.cdb_rob_id          = rob_id_q;
    assign mul.cdb_rd_s            = rd_s_q;
    assign mul.cdb_rd_v            = rd_v_q;
endmodule

// File: tb/tb_multiplier_fu.sv
// Bench for multiplier_fu: directed RV32M corner cases, back-pressure, ignored
// issues, mid-operation reset and randomized operations against a 64-bit model.
module tb_multiplier_fu;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    multiplier_fu_if bus ();

    multiplier_fu dut (
        .clk (clk),
        .rst (rst),
        .mul (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: extend each operand per RV32M rules, multiply in 64 bits, pick a word.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] rob, input logic [5:0] rd);
        bus.start_calculate = 1'b1;
        bus.funct3          = f3;
        bus.rs1_v           = a;
        bus.rs2_v           = b;
        bus.rob_id_in       = rob;
        bus.rd_s_in         = rd;
        step();
        bus.start_calculate = 1'b0;
        bus.funct3          = 3'($urandom);
        bus.rs1_v           = $urandom;
        bus.rs2_v           = $urandom;
        bus.rob_id_in       = 3'($urandom);
        bus.rd_s_in         = 6'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rob, input logic [5:0] rd, input int hold,
                          input bit poke, output int t_issue);
        logic [31:0] want_v;
        want_v = ref_mul(f3[1:0], a, b);
        check_val("ready_idle", 64'(bus.fu_ready), 64'd1);
        t_issue = cyc;
        do_issue(f3, a, b, rob, rd);
        check_val("ready_busy", 64'(bus.fu_ready), 64'd0);
        for (int c = 1; c <= 32; c++) begin
            check_val("early_valid", 64'(bus.ready_for_writeback), 64'd0);
            if (poke && c == 10) begin
                bus.start_calculate = 1'b1;
                bus.cdb_ack         = 1'b1;
                bus.funct3          = ~f3;
                bus.rs1_v           = ~a;
                bus.rs2_v           = a ^ b ^ 32'h1;
                bus.rob_id_in       = ~rob;
                bus.rd_s_in         = ~rd;
            end
            step();
            if (poke && c == 10) begin
                bus.start_calculate = 1'b0;
                bus.cdb_ack         = 1'b0;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            check_val("valid", 64'(bus.ready_for_writeback), 64'd1);
            check_val("rd_v", 64'(bus.cdb_rd_v), 64'(want_v));
            check_val("rob_id", 64'(bus.cdb_rob_id), 64'(rob));
            check_val("rd_s", 64'(bus.cdb_rd_s), 64'(rd));
            check_val("ready_held", 64'(bus.fu_ready), 64'd0);
            if (h < hold) step();
        end
        bus.cdb_ack = 1'b1;
        step();
        bus.cdb_ack = 1'b0;
        check_val("valid_drop", 64'(bus.ready_for_writeback), 64'd0);
        check_val("ready_after_ack", 64'(bus.fu_ready), 64'd1);
    endtask

    // Reset asserted wait_cyc cycles after issue, held for two clock edges.
    task automatic abort_run(input int wait_cyc);
        do_issue(3'b001, $urandom, $urandom, 3'd6, 6'd33);
        repeat (wait_cyc - 1) step();
        rst = 1'b1;
        #1;
        check_val("rst_ready_0", 64'(bus.fu_ready), 64'd0);
        step();
        check_val("rst_ready_1", 64'(bus.fu_ready), 64'd0);
        check_val("rst_valid", 64'(bus.ready_for_writeback), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check_val("rst_release_ready", 64'(bus.fu_ready), 64'd1);
        check_val("rst_release_valid", 64'(bus.ready_for_writeback), 64'd0);
        repeat (40) step();
        check_val("rst_no_broadcast", 64'(bus.ready_for_writeback), 64'd0);
        check_val("rst_still_ready", 64'(bus.fu_ready), 64'd1);
    endtask

    initial begin
        int t1;
        int t2;
        logic [2:0] f3;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.start_calculate = 1'b0;
        bus.funct3          = 3'b0;
        bus.rs1_v           = '0;
        bus.rs2_v           = '0;
        bus.rob_id_in       = '0;
        bus.rd_s_in         = '0;
        bus.cdb_ack         = 1'b0;

        step();
        check_val("reset_ready", 64'(bus.fu_ready), 64'd0);
        check_val("reset_valid", 64'(bus.ready_for_writeback), 64'd0);
        check_val("reset_rob", 64'(bus.cdb_rob_id), 64'd0);
        check_val("reset_rd_s", 64'(bus.cdb_rd_s), 64'd0);
        check_val("reset_rd_v", 64'(bus.cdb_rd_v), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check_val("reset_release_ready", 64'(bus.fu_ready), 64'd1);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 3'd5, 6'd12, 0, 1'b0, t1);
        check_val("mul_expect", 64'(ref_mul(2'b00, 32'd7, 32'hFFFF_FFFD)), 64'h0000_0000_FFFF_FFEB);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 3'd1, 6'd2, 0, 1'b0, t1);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 6'd3, 0, 1'b0, t1);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 6'd4, 0, 1'b0, t1);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 6'd5, 0, 1'b0, t1);

        run_op(3'b010, 32'h8000_0000, 32'h1234_5678, 3'd7, 6'd40, 10, 1'b0, t1);
        run_op(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'd2, 6'd17, 0, 1'b1, t1);

        run_op(3'b000, 32'h0001_0003, 32'h0002_0005, 3'd1, 6'd9, 0, 1'b0, t1);
        run_op(3'b011, 32'h8765_4321, 32'h0F0F_0F0F, 3'd6, 6'd63, 0, 1'b0, t2);
        check_val("b2b_spacing", 64'(t2 - t1), 64'd34);

        abort_run(10);
        abort_run(34);

        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom);
            run_op(f3, pick_operand(), pick_operand(), 3'($urandom), 6'($urandom),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), t1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
